// File: rtl/alu_issue.sv
// Operand dispatcher in front of the SIMD ALU: registers one operation onto the ALU inputs,
// waits out the integer or floating-point latency, then presents the captured result.
module alu_issue #(
    parameter int bw      = 32,
    parameter int INT_LAT = 1,
    parameter int FP_LAT  = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [bw-1:0] in_A,
    input  logic [bw-1:0] in_B,
    input  logic [3:0]    in_mode,
    input  logic          in_dtype,
    output logic [bw-1:0] alu_A,
    output logic [bw-1:0] alu_B,
    output logic [3:0]    alu_mode,
    output logic          alu_dtype,
    input  logic [bw-1:0] alu_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [bw-1:0] out_result,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter is loaded with latency-1 so that capture lands exactly L edges after accept.
    localparam logic [3:0] INT_CNT = 4'(INT_LAT - 1);
    localparam logic [3:0] FP_CNT  = 4'(FP_LAT - 1);

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic [bw-1:0]   a_reg, b_reg;
    logic [3:0]      mode_reg;
    logic            dtype_reg;
    logic [bw-1:0]   result_reg;
    logic            ready_next;
    logic            accept;
    logic            capture;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ready_next = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_next = 1'b1;
                accept     = in_valid;
            end
            EXEC: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // Delivering the result frees the slot, so a waiting operation can issue on the same edge.
                if (out_ready) begin
                    ready_next = 1'b1;
                    accept     = in_valid;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (accept) begin
            state_next = EXEC;
            cnt_next   = in_dtype ? FP_CNT : INT_CNT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            mode_reg  <= 4'd0;
            dtype_reg <= 1'b0;
        end else if (accept) begin
            a_reg     <= in_A;
            b_reg     <= in_B;
            mode_reg  <= in_mode;
            dtype_reg <= in_dtype;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg <= '0;
        end else if (capture) begin
            result_reg <= alu_result;
        end
    end

    assign in_ready   = ready_next & ~rst;
    assign alu_A      = a_reg;
    assign alu_B      = b_reg;
    assign alu_mode   = mode_reg;
    assign alu_dtype  = dtype_reg;
    assign out_result = result_reg;
    assign out_valid  = (state_reg == DONE);
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: an ALU model that only yields a valid result after its latency,
// and a transaction-level reference model checked every cycle.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_A;
    logic [31:0] in_B;
    logic [3:0]  in_mode;
    logic        in_dtype;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [3:0]  alu_mode;
    logic        alu_dtype;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;

    always #5 clk = ~clk;

    alu_issue #(.bw(32), .INT_LAT(1), .FP_LAT(7)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_mode(in_mode), .in_dtype(in_dtype),
        .alu_A(alu_A), .alu_B(alu_B), .alu_mode(alu_mode), .alu_dtype(alu_dtype),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .busy(busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic d);
        return d ? 7 : 1;
    endfunction

    function automatic real to_real(input logic [31:0] f);
        logic [63:0] x;
        if (f[30:23] == 8'd0) return 0.0;
        x = 64'd0;
        x[63]    = f[31];
        x[62:52] = {3'b000, f[30:23]} + 11'd896;
        x[51:29] = f[22:0];
        return $bitstoreal(x);
    endfunction

    function automatic logic [31:0] from_real(input real r);
        logic [63:0] x;
        logic [10:0] e;
        x = $realtobits(r);
        if (x[62:52] <= 11'd896) return {x[63], 31'd0};
        e = x[62:52] - 11'd896;
        return {x[63], e[7:0], x[51:29]};
    endfunction

    // Integer path: A+B with the mode folded in so a corrupted mode shows up in the result.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] m, input logic d);
        if (d) return from_real(to_real(a) + to_real(b));
        return (a + b) ^ {28'd0, m};
    endfunction

    // ALU model: output is garbage until its inputs have been stable for the path latency.
    logic [68:0] snap = 'x;
    int          stab = 0;
    always @(negedge clk) begin
        if ({alu_A, alu_B, alu_mode, alu_dtype} !== snap) begin
            snap <= {alu_A, alu_B, alu_mode, alu_dtype};
            stab <= 0;
        end else begin
            stab <= stab + 1;
        end
    end
    assign alu_result = (stab >= lat_of(alu_dtype) - 1) ?
                        alu_fn(alu_A, alu_B, alu_mode, alu_dtype) : (32'hBAD0_0000 | 32'(stab));

    // Reference model: at most one operation in flight, result due L edges after accept.
    bit          m_have = 0;
    int          m_e = 0;
    int          m_l = 1;
    int          cyc = 0;
    logic [31:0] m_a = 0, m_b = 0, m_res = 0, m_last = 0;
    logic [3:0]  m_mode = 0;
    logic        m_dtype = 0;
    logic [31:0] obs_q[$];

    task automatic check_outputs();
        check_val("out_valid", 32'(out_valid), 32'(m_have && (cyc >= m_e + m_l)));
        check_val("busy", 32'(busy), 32'(m_have));
        check_val("out_result", out_result, m_last);
        check_val("alu_A", alu_A, m_a);
        check_val("alu_B", alu_B, m_b);
        check_val("alu_mode", 32'(alu_mode), 32'(m_mode));
        check_val("alu_dtype", 32'(alu_dtype), 32'(m_dtype));
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic step(input logic v, input logic r, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] m, input logic d);
        logic done_prev;
        logic exp_rdy;
        in_valid = v; out_ready = r; in_A = a; in_B = b; in_mode = m; in_dtype = d;
        #1;
        done_prev = m_have && (cyc >= m_e + m_l);
        exp_rdy   = !m_have || (done_prev && r);
        check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (out_valid && r) obs_q.push_back(out_result);
        @(posedge clk);
        cyc++;
        if (done_prev && r) m_have = 0;
        if (v && exp_rdy) begin
            m_have = 1; m_e = cyc; m_l = lat_of(d);
            m_a = a; m_b = b; m_mode = m; m_dtype = d;
            m_res = alu_fn(a, b, m, d);
        end
        if (m_have && cyc == m_e + m_l) m_last = m_res;
        @(negedge clk);
        $display("[TB] cyc=%0d v=%0b r=%0b in_ready=%0b out_valid=%0b out_result=%h",
                 cyc, v, r, in_ready, out_valid, out_result);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_out_result"}, out_result, 32'd0);
        check_val({tag, "_alu_A"}, alu_A, 32'd0);
        check_val({tag, "_alu_B"}, alu_B, 32'd0);
        check_val({tag, "_alu_mode"}, 32'(alu_mode), 32'd0);
        check_val({tag, "_alu_dtype"}, 32'(alu_dtype), 32'd0);
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_reset_outputs(tag);
        m_have = 0; m_a = 0; m_b = 0; m_mode = 0; m_dtype = 0; m_last = 0;
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset %s released", tag);
    endtask

    function automatic logic [31:0] rand_float();
        return {1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)};
    endfunction

    initial begin
        logic [31:0] a, b;
        logic        v, r, d;
        rst = 1'b1; in_valid = 0; out_ready = 0; in_A = 0; in_B = 0; in_mode = 0; in_dtype = 0;
        #2 check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        // Integer issue.
        step(1'b1, 1'b1, 32'd5, 32'd7, 4'd0, 1'b0);
        check_val("int_alu_A_held", alu_A, 32'd5);
        idle(1);
        check_val("int_result", out_result, 32'd12);
        check_val("int_out_valid", 32'(out_valid), 32'd1);
        idle(1);

        // Float issue: result 7 edges after accept.
        step(1'b1, 1'b1, 32'h3F80_0000, 32'h4000_0000, 4'd0, 1'b1);
        idle(6);
        check_val("fp_not_yet", 32'(out_valid), 32'd0);
        idle(1);
        check_val("fp_result", out_result, 32'h4040_0000);
        idle(1);

        // Backpressure with a pending operation.
        obs_q.delete();
        step(1'b1, 1'b1, 32'd100, 32'd23, 4'd0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd9, 32'd1, 4'd0, 1'b0);
        check_val("bp_held", out_result, 32'd123);
        step(1'b1, 1'b1, 32'd9, 32'd1, 4'd0, 1'b0);
        check_val("bp_deliver_once", 32'(obs_q.size()), 32'd1);
        check_val("bp_pending_accepted", alu_A, 32'd9);
        idle(2);

        // Back-to-back integer operations.
        obs_q.delete();
        for (int i = 0; i < 4; i++) begin
            a = 32'(i * 10 + 1);
            b = 32'(i * 3);
            step(1'b1, 1'b1, a, b, 4'd0, 1'b0);
            step(1'b1, 1'b1, a, b, 4'd0, 1'b0);
        end
        idle(1);
        check_val("b2b_count", 32'(obs_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs_q.size(); i++)
            check_val("b2b_order", obs_q[i], 32'(i * 13 + 1));
        idle(1);

        // Reset during float EXEC, then a clean float operation.
        step(1'b1, 1'b1, 32'h4040_0000, 32'h3F80_0000, 4'd5, 1'b1);
        idle(2);
        do_reset("mid_exec");
        idle(10);
        step(1'b1, 1'b1, 32'h4000_0000, 32'h4000_0000, 4'd0, 1'b1);
        idle(7);
        check_val("post_reset_fp", out_result, 32'h4080_0000);
        idle(1);

        // Mixed latency with in_dtype toggling during EXEC.
        step(1'b1, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 4'd0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 1'(i));
        step(1'b1, 1'b1, 32'd2, 32'd3, 4'd1, 1'b0);
        check_val("mix_fp_result", out_result, 32'h4000_0000);
        step(1'b1, 1'b1, 32'd2, 32'd3, 4'd1, 1'b0);
        idle(1);
        check_val("mix_int_result", out_result, 32'd4);
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            v = 1'($urandom_range(3) != 0);
            r = 1'($urandom_range(3) != 0);
            d = 1'($urandom);
            a = d ? rand_float() : $urandom;
            b = d ? rand_float() : $urandom;
            step(v, r, a, b, 4'($urandom), d);
            if ($urandom_range(149) == 0) do_reset("rand");
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Single-issue operand dispatcher sitting directly upstream of the SIMD ALU. It accepts one operation (A, B, mode, dtype) through a valid/ready handshake and registers it onto the ALU inputs. It holds those inputs stable for the integer or floating-point path latency, then captures the ALU result into an output register with its own valid/ready handshake. This lets a combinational integer path and a multi-cycle floating-point path share one clean, backpressured interface.

## Interface
- bw, 32, data width of operands and result; matches the ALU.
- INT_LAT, 1, cycles from issue to result capture when dtype=0; legal range 1..15.
- FP_LAT, 7, cycles from issue to result capture when dtype=1; legal range 1..15.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream operation valid.
- in_ready  output  1  block can accept an operation this cycle.
- in_A  input  bw  operand A.
- in_B  input  bw  operand B.
- in_mode  input  4  ALU operation code, passed through unmodified.
- in_dtype  input  1  0 = integer path, 1 = floating-point path.
- alu_A  output  bw  registered operand A to the ALU.
- alu_B  output  bw  registered operand B to the ALU.
- alu_mode  output  4  registered mode to the ALU.
- alu_dtype  output  1  registered dtype to the ALU.
- alu_result  input  bw  ALU result.
- out_valid  output  1  out_result holds a completed result.
- out_ready  input  1  downstream accepts the result.
- out_result  output  bw  captured result.
- busy  output  1  high in EXEC or DONE.

## Operation
- FSM states: IDLE, EXEC, DONE. Counter cnt is 4 bits wide.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_A/in_B/in_mode/in_dtype into the alu_* registers, load cnt = (in_dtype ? FP_LAT : INT_LAT) − 1, go to EXEC.
- EXEC:
  - in_ready=0. The alu_* registers hold constant.
  - If cnt≠0, decrement cnt.
  - If cnt=0, capture alu_result into out_result and go to DONE.
- DONE:
  - out_valid=1. out_result holds until the handshake completes.
  - If out_ready=0, stay in DONE.
  - If out_ready=1 and in_valid=0, go to IDLE.
  - If out_ready=1 and in_valid=1, accept the new operation in the same cycle (in_ready=1 in DONE when out_ready=1), reload alu_* and cnt, go to EXEC.
- in_ready is combinational: (state==IDLE) || (state==DONE && out_ready).
- in_valid while in EXEC, or in DONE with out_ready=0, is not accepted. The upstream holds its operation; no input is dropped or corrupted.
- The dtype latched at issue selects the latency. A later change on in_dtype has no effect on an in-flight operation.
- The ALU result is never modified, truncated, or sign-handled here.

## Timing
- Reset values:
  - state=IDLE, cnt=0.
  - alu_A=0, alu_B=0, alu_mode=0, alu_dtype=0.
  - out_result=0, out_valid=0, busy=0.
  - in_ready=1 while rst is deasserted and state=IDLE; in_ready=0 while rst=1.
- Latency:
  - The accept edge is E (in_valid && in_ready).
  - alu_* change at E.
  - alu_result is sampled at edge E+L, where L is INT_LAT or FP_LAT.
  - out_valid is high from edge E+L.
- Throughput: one operation per L+1 cycles with out_ready held high.
- Reset mid-operation: state returns to IDLE immediately and asynchronously. The in-flight operation and any undelivered result are discarded. out_valid drops without a handshake.
- alu_* outputs change only at an accept edge or on reset.

## Test plan
- Integer issue, bench ALU model returning A+B: in_A=5, in_B=7, dtype=0, out_ready=1, INT_LAT=1.
  - Expect out_valid at accept edge +1 with out_result=12.
  - Expect alu_A=5 held for 1 cycle.
- Float issue, FP_LAT=7: A=32'h3F800000, B=32'h40000000, dtype=1, model returns a float sum.
  - Expect out_valid exactly 7 edges after accept with out_result=32'h40400000.
  - Expect in_ready=0 for those 7 cycles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Expect out_result to stay constant.
  - Expect in_ready=0 and a pending in_valid not accepted.
  - On out_ready=1, expect the result to be delivered once and the pending operation accepted the same cycle.
- Back-to-back: four integer operations with in_valid and out_ready held high.
  - Expect accepts every 2 cycles, results in order, and no duplicates.
- Reset during EXEC of a float operation (cycle 3 of 7).
  - Expect all outputs at reset values immediately and no later out_valid.
  - Expect the next operation after reset release to complete normally.
- Mixed latency: float operation immediately followed by an integer operation.
  - Expect each to use its own latency, 7 then 1.
  - Expect in_dtype toggling during EXEC not to alter the first operation's latency.
